io_out_buffer: RTL and testbench
================================

IO_OUT_BUFFER -- requirements
Module: io_out_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, at least 4.
REQ-002 Parameter AFULL_MARGIN, default 2, free-entry margin at which back-pressure asserts.
REQ-003 Port clk_in  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 Port rst_in  input  1  reset, asynchronous and active-low.
REQ-005 Port rdy_in  input  1  CPU ready; captures from the CPU bus SHALL be gated by it.
REQ-006 Port mem_a  input  32  CPU address bus; only bits 17:16 and 2:0 decoded.
REQ-007 Port mem_dout  input  8  CPU write-data byte.
REQ-008 Port mem_wr  input  1  CPU write strobe, 1 = write.
REQ-009 Port io_buffer_full  output  1  back-pressure to CPU.
REQ-010 Port tx_data  output  8  byte offered to UART transmitter.
REQ-011 Port tx_valid  output  1  tx_data valid.
REQ-012 Port tx_ready  input  1  UART accepts the byte this cycle.
REQ-013 Port program_finish  output  1  program stop fully flushed.
REQ-014 Port ovf  output  1  sticky overflow flag.
REQ-015 Port count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 io_wr SHALL be rdy_in & mem_wr & (mem_a[17:16]==2'b11).
REQ-017 Push SHALL occur when io_wr, mem_a[2:0]==3'b000, mem_dout!=8'h00, state RUN and FIFO not full (or full with a pop in the same cycle).
REQ-018 Writes of 8'h00 to 0x30000 SHALL be ignored.
REQ-019 Pop SHALL occur when tx_valid & tx_ready; pop is not gated by rdy_in.
REQ-020 tx_data SHALL be the head entry and tx_valid = (count!=0) in RUN and DRAIN.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, at any occupancy including full and empty-with-bypass disallowed (a pushed byte appears on tx_data no earlier than the next cycle).
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-023 io_buffer_full SHALL be combinational from registered count: 1 when count >= DEPTH-AFULL_MARGIN.
REQ-024 Push attempt while full without same-cycle pop SHALL be dropped and FIFO contents unchanged.
REQ-025 State machine RUN, DRAIN, SEND_NUL, DONE; RUN -> DRAIN on io_wr with mem_a[2:0]==3'b100 (data ignored).
REQ-026 DRAIN: pushes ignored; DRAIN -> SEND_NUL in the cycle after count reaches 0.
REQ-027 SEND_NUL: tx_valid=1, tx_data=8'h00; SEND_NUL -> DONE on tx_ready.
REQ-028 DONE: program_finish=1, tx_valid=0, all CPU writes ignored, held until reset.
REQ-029 Stop write while count==0 SHALL pass through DRAIN for exactly one cycle.

Reset
REQ-030 On rst_in low, immediately: pointers, count=0, state RUN, tx_valid=0, tx_data=8'h00, io_buffer_full=0, program_finish=0, ovf=0.
REQ-031 Reset mid-operation SHALL discard all buffered bytes and any pending stop; FIFO storage need not be cleared.
REQ-032 First push SHALL be accepted on the first rising edge after rst_in deasserts.

Configuration
REQ-033 Macro IO_OUT_BUFFER_OVF_EN: when defined, a dropped push per REQ-024 SHALL set ovf, sticky until reset.
REQ-034 Without IO_OUT_BUFFER_OVF_EN, ovf SHALL be constant 0 and no overflow logic synthesised; all other behaviour identical.

Verification
REQ-035 Write 0x41,0x42,0x43 to 0x30000, tx_ready=1 -> tx_data 0x41,0x42,0x43 in order, count returns 0.
REQ-036 Write 0x00 to 0x30000 -> count stays 0, tx_valid stays 0.
REQ-037 DEPTH=16, AFULL_MARGIN=2, tx_ready=0, 14 writes -> io_buffer_full=1 at count 14; 3 more writes -> count=16, ovf=1 only with macro.
REQ-038 Count=16, push and pop same cycle -> count=16, new byte at tail, ovf unchanged.
REQ-039 Buffer 0x61,0x62, write 0x30004, tx_ready=1 -> 0x61,0x62,0x00 on tx, then program_finish=1; later 0x30000 write ignored.
REQ-040 rst_in low with count=5 in DRAIN -> count=0, state RUN, program_finish=0, tx_valid=0 immediately.

Source files
------------

// File: rtl/io_out_buffer.sv
// io_out_buffer: CPU-to-UART output byte FIFO with a program-stop sequence.
//
// The CPU writes bytes to 0x30000 (bits 17:16 and 2:0 decoded). Non-zero bytes
// are queued and offered to the UART with a valid/ready handshake. A write to
// 0x30004 requests program stop. The buffer then drains and sends a single NUL
// byte. After that it raises program_finish and ignores the CPU until reset.
//
// Optional feature: define IO_OUT_BUFFER_OVF_EN to build the sticky overflow
// flag. Without the macro, ovf is tied to 0 and no overflow logic exists.
module io_out_buffer #(
   parameter int DEPTH        = 16,  // power of two, >= 4
   parameter int AFULL_MARGIN = 2    // free entries left when back-pressure asserts
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic [31:0]              mem_a,
   input  logic [7:0]               mem_dout,
   input  logic                     mem_wr,
   output logic                     io_buffer_full,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     program_finish,
   output logic                     ovf,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_LEVEL = CW'(DEPTH - AFULL_MARGIN);

   typedef enum logic [1:0] {
      ST_RUN,       // normal operation, CPU bytes accepted
      ST_DRAIN,     // stop requested, emptying the FIFO
      ST_SEND_NUL,  // offering the terminating 8'h00
      ST_DONE       // finished, everything ignored until reset
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [7:0]       mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [7:0]       head;

   logic             io_wr;
   logic             data_sel;
   logic             stop_sel;
   logic             push_req;
   logic             push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;

   // Only bits 17:16 and 2:0 of the address take part in decoding.
   logic             unused_addr_bits;
   assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:3]};

   // CPU bus decode. The rdy_in gate applies to CPU captures only.
   assign io_wr    = rdy_in & mem_wr & (mem_a[17:16] == 2'b11);
   assign data_sel = (mem_a[2:0] == 3'b000);
   assign stop_sel = (mem_a[2:0] == 3'b100);

   // FIFO status from the registered occupancy.
   assign fifo_full  = (count == FULL_LEVEL);
   assign fifo_empty = (count == '0);
   assign head       = mem[rd_ptr];

   // Back-pressure uses only the registered count, so the CPU sees no
   // combinational path from its own write strobe.
   assign io_buffer_full = (count >= AFULL_LEVEL);

   // A zero byte is never queued. Pushes are accepted only in RUN.
   assign push_req = io_wr & data_sel & (mem_dout != 8'h00) & (state == ST_RUN);

   // The FIFO is popped only while it is the source of tx_data. The NUL byte
   // sent in SEND_NUL does not come from storage.
   assign fifo_pop = tx_valid & tx_ready & ((state == ST_RUN) | (state == ST_DRAIN));

   // When the FIFO is full, a push is still allowed if the head leaves in the
   // same cycle.
   assign push = push_req & (~fifo_full | fifo_pop);

   // State register
   // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs
   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_next     = state;
      tx_valid       = 1'b0;
      tx_data        = 8'h00;
      program_finish = 1'b0;
      case (state)
         ST_RUN: begin
            tx_valid = ~fifo_empty;
            tx_data  = fifo_empty ? 8'h00 : head;
            if (io_wr && stop_sel) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            tx_valid = ~fifo_empty;
            tx_data  = fifo_empty ? 8'h00 : head;
            // Leave on the cycle after the registered count shows empty.
            if (fifo_empty) begin
               state_next = ST_SEND_NUL;
            end
         end
         ST_SEND_NUL: begin
            tx_valid = 1'b1;
            tx_data  = 8'h00;
            if (tx_ready) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            program_finish = 1'b1;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   // Pointer and occupancy tracking. Pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, fifo_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage write port
   // NOTE: storage has no reset; validity is carried by the pointers and count alone.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem[wr_ptr] <= mem_dout;
      end
   end

`ifdef IO_OUT_BUFFER_OVF_EN
   logic drop;
   assign drop = push_req & fifo_full & ~fifo_pop;

   // Sticky overflow flag, set by any push dropped for lack of space
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_io_out_buffer.sv
// tb_io_out_buffer: self-checking bench for io_out_buffer (DEPTH=16, AFULL_MARGIN=2).
// A queue-based reference model tracks buffered bytes, the stop phase and the
// overflow flag. Every cycle the model is compared with all DUT outputs. There
// are also table vectors and directed corner-case sequences.
module tb_io_out_buffer;

   localparam int DEPTH        = 16;
   localparam int AFULL_MARGIN = 2;
   localparam int CW           = $clog2(DEPTH) + 1;
   localparam logic [31:0] A_DATA = 32'h0003_0000;
   localparam logic [31:0] A_STOP = 32'h0003_0004;

`ifdef IO_OUT_BUFFER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          rdy_in;
   logic [31:0]   mem_a;
   logic [7:0]    mem_dout;
   logic          mem_wr;
   logic          io_buffer_full;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          program_finish;
   logic          ovf;
   logic [CW-1:0] count;

   io_out_buffer #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .mem_a          (mem_a),
      .mem_dout       (mem_dout),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .program_finish (program_finish),
      .ovf            (ovf),
      .count          (count)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp  = 0;
   int n_fail = 0;

   // ---------------- reference model ----------------
   localparam int P_RUN = 0, P_DRAIN = 1, P_NUL = 2, P_DONE = 3;
   logic [7:0] mq[$];
   int         phase = P_RUN;
   bit         m_ovf = 1'b0;

   function automatic void model_reset();
      mq.delete();
      phase = P_RUN;
      m_ovf = 1'b0;
   endfunction

   function automatic void model_step(bit rdy, bit wr, logic [31:0] a, logic [7:0] d, bit txr);
      bit cpu_wr;
      bit popped;
      int nxt;
      cpu_wr = rdy && wr && (a[17:16] == 2'b11);
      popped = (phase == P_RUN || phase == P_DRAIN) && mq.size() != 0 && txr;
      nxt    = phase;
      if (phase == P_RUN && cpu_wr && a[2:0] == 3'b100) nxt = P_DRAIN;
      else if (phase == P_DRAIN && mq.size() == 0)      nxt = P_NUL;
      else if (phase == P_NUL && txr)                   nxt = P_DONE;
      if (popped) void'(mq.pop_front());
      if (phase == P_RUN && cpu_wr && a[2:0] == 3'b000 && d != 8'h00) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else if (OVF_EN)       m_ovf = 1'b1;
      end
      phase = nxt;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      bit exp_valid;
      exp_valid = ((phase == P_RUN || phase == P_DRAIN) && mq.size() != 0) || phase == P_NUL;
      check("count", 32'(count), 32'(mq.size()));
      check("tx_valid", 32'(tx_valid), 32'(exp_valid));
      if (exp_valid) check("tx_data", 32'(tx_data), (phase == P_NUL) ? 32'h0 : 32'(mq[0]));
      check("io_buffer_full", 32'(io_buffer_full), 32'(mq.size() >= DEPTH - AFULL_MARGIN));
      check("program_finish", 32'(program_finish), 32'(phase == P_DONE));
      check("ovf", 32'(ovf), 32'(m_ovf));
   endtask

   // One clock: drive the inputs, let the edge happen, then compare just after it.
   task automatic step(input bit rdy, input bit wr, input logic [31:0] a,
                       input logic [7:0] d, input bit txr);
      rdy_in = rdy; mem_wr = wr; mem_a = a; mem_dout = d; tx_ready = txr;
      @(posedge clk_in);
      model_step(rdy, wr, a, d, txr);
      #1;
      check_model();
   endtask

   task automatic wr_data(input logic [7:0] d, input bit txr);
      step(1'b1, 1'b1, A_DATA, d, txr);
   endtask

   task automatic idle(input bit txr);
      step(1'b1, 1'b0, A_DATA, 8'h00, txr);
   endtask

   // Assert reset mid-cycle and check that outputs clear at once. Hold reset
   // across an edge with a write pending. Release reset at a falling edge.
   task automatic do_reset();
      @(negedge clk_in);
      #2;
      rst_in = 1'b0;
      #1;
      model_reset();
      check_model();
      check("rst tx_valid", 32'(tx_valid), 32'h0);
      check("rst tx_data", 32'(tx_data), 32'h0);
      rdy_in = 1'b1; mem_wr = 1'b1; mem_a = A_DATA; mem_dout = 8'h5A; tx_ready = 1'b0;
      @(posedge clk_in);
      #1;
      check("write under reset", 32'(count), 32'h0);
      @(negedge clk_in);
      mem_wr = 1'b0;
      rst_in = 1'b1;
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      bit          rdy;
      bit          wr;
      logic [31:0] a;
      logic [7:0]  d;
      bit          txr;
      int          exp_count;
      bit          exp_valid;
      logic [7:0]  exp_data;
      bit          exp_full;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [7:0] got[$];
      logic [7:0] exp_b[3];
      int         ready_bias;
      int         sel;
      logic [31:0] ra;

      rst_in = 1'b1; rdy_in = 1'b0; mem_wr = 1'b0; mem_a = '0; mem_dout = '0; tx_ready = 1'b0;
      #3;
      do_reset();

      // Basic traffic, the zero-byte filter and address/strobe decoding.
      vecs[0]  = '{1'b1, 1'b1, A_DATA,        8'h41, 1'b0, 1, 1'b1, 8'h41, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, A_DATA,        8'h42, 1'b0, 2, 1'b1, 8'h41, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, A_DATA,        8'h43, 1'b1, 2, 1'b1, 8'h42, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, A_DATA,        8'h00, 1'b1, 1, 1'b1, 8'h43, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, A_DATA,        8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, A_DATA,        8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, A_DATA,        8'h55, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 32'h0002_0000, 8'h55, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 32'h0003_0001, 8'h55, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, A_DATA,        8'h55, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 32'hFFF3_0008, 8'h66, 1'b0, 1, 1'b1, 8'h66, 1'b0};
      vecs[11] = '{1'b1, 1'b0, A_DATA,        8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rdy, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].txr);
         check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid)
            check($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d full", i), 32'(io_buffer_full), 32'(vecs[i].exp_full));
      end

      // Fill to the back-pressure threshold, then to full, then past full.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         wr_data(8'(i + 1), 1'b0);
         if (i == 12) check("full at 13", 32'(io_buffer_full), 32'h0);
      end
      check("count 14", 32'(count), 32'd14);
      check("full at 14", 32'(io_buffer_full), 32'h1);
      for (int i = 14; i < 17; i++) wr_data(8'(i + 1), 1'b0);
      check("count capped", 32'(count), 32'd16);
      check("ovf after drop", 32'(ovf), 32'(OVF_EN));

      // Push and pop together while full: count holds and the new byte lands at the tail.
      wr_data(8'h77, 1'b1);
      check("full push+pop count", 32'(count), 32'd16);
      check("full push+pop head", 32'(tx_data), 32'h02);
      check("ovf unchanged", 32'(ovf), 32'(OVF_EN));
      got.delete();
      for (int i = 0; i < 16; i++) begin
         if (tx_valid) got.push_back(tx_data);
         idle(1'b1);
      end
      check("drained bytes", 32'(got.size()), 32'd16);
      if (got.size() == 16) check("tail byte", 32'(got[15]), 32'h77);
      check("ovf sticky", 32'(ovf), 32'(OVF_EN));

      // Stop sequence: buffered bytes, then NUL, then finish. CPU is ignored afterwards.
      do_reset();
      wr_data(8'h61, 1'b0);
      wr_data(8'h62, 1'b0);
      step(1'b1, 1'b1, A_STOP, 8'hAB, 1'b0);
      check("stop keeps bytes", 32'(count), 32'd2);
      wr_data(8'h63, 1'b0);
      check("push in drain ignored", 32'(count), 32'd2);
      got.delete();
      for (int k = 0; k < 10 && !program_finish; k++) begin
         if (tx_valid) got.push_back(tx_data);
         idle(1'b1);
      end
      exp_b = '{8'h61, 8'h62, 8'h00};
      check("stop tx bytes", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3 && i < got.size(); i++)
         check($sformatf("stop byte%0d", i), 32'(got[i]), 32'(exp_b[i]));
      check("program_finish", 32'(program_finish), 32'h1);
      wr_data(8'h44, 1'b1);
      check("done ignores write", 32'(count), 32'h0);
      check("done tx_valid", 32'(tx_valid), 32'h0);

      // Stop with an empty FIFO: exactly one cycle in DRAIN, then NUL waits for ready.
      do_reset();
      step(1'b1, 1'b1, A_STOP, 8'h00, 1'b0);
      check("empty stop drain valid", 32'(tx_valid), 32'h0);
      idle(1'b0);
      check("empty stop nul valid", 32'(tx_valid), 32'h1);
      check("empty stop nul data", 32'(tx_data), 32'h0);
      idle(1'b0);
      check("nul held", 32'(tx_valid), 32'h1);
      idle(1'b1);
      check("empty stop finish", 32'(program_finish), 32'h1);

      // Reset while draining with 5 bytes, then push on the first edge after release.
      do_reset();
      for (int i = 0; i < 5; i++) wr_data(8'h30 + 8'(i), 1'b0);
      step(1'b1, 1'b1, A_STOP, 8'h00, 1'b0);
      check("pre-reset count", 32'(count), 32'd5);
      do_reset();
      check("post-reset finish", 32'(program_finish), 32'h0);
      wr_data(8'h39, 1'b0);
      check("first push count", 32'(count), 32'd1);
      check("first push data", 32'(tx_data), 32'h39);

      // Randomized traffic against the model.
      ready_bias = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 500 == 0) ready_bias = $urandom_range(10, 90);
         sel = $urandom_range(0, 99);
         ra  = $urandom();
         step($urandom_range(0, 9) != 0,
              1'($urandom_range(0, 1)),
              (sel < 80) ? A_DATA : (sel == 80) ? A_STOP : ra,
              ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom()),
              $urandom_range(0, 99) < ready_bias);
         if (phase == P_DONE && $urandom_range(0, 3) == 0) do_reset();
         else if ($urandom_range(0, 299) == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
